grid_memory: RTL

Cell store for the 32×24 playfield, sitting between the snake state machine and the VGA draw stage. Accepts the controller's held `{x, y, function}` write word every clock and serves its combinational collision read port. Provides a registered read port for the pixel renderer. Owns the clear sweep that empties the board after reset or on request, and reports walls (ROCK) for any coordinate outside the grid.

---
 rtl/grid_memory.sv | 87 ++++++++
 1 files changed

// File: rtl/grid_memory.sv
// grid_memory: 32x24 playfield cell store with collision/VGA read ports and a clear sweep.
// Define GRID_BORDER_ROCK_EN to make the sweep lay a ROCK border instead of an empty board.
module grid_memory #(
    parameter int GRID_SIZE_X = 32,
    parameter int GRID_SIZE_Y = 24,
    parameter int CELL_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [35:0]       rect_write,
    input  logic [31:0]       rect_read_addr,
    output logic [CELL_W-1:0] rect_read_in,
    input  logic [4:0]        vga_x,
    input  logic [4:0]        vga_y,
    output logic [CELL_W-1:0] vga_cell,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              oob_write
);
    localparam int NCELL = GRID_SIZE_X * GRID_SIZE_Y;
    localparam logic [CELL_W-1:0] C_NULL = '0;
    localparam logic [CELL_W-1:0] C_ROCK = CELL_W'(2);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state_q, state_d;
    logic [9:0]        cnt_q, cnt_d;
    logic [CELL_W-1:0] mem_q [NCELL];
    logic [CELL_W-1:0] vga_cell_q, sweep_val;
    logic              oob_q;
    logic [15:0]       wx, wy, rx, ry;
    logic              wr_ok, rd_ok;

    assign wx    = rect_write[35:20];
    assign wy    = rect_write[19:4];
    assign rx    = rect_read_addr[31:16];
    assign ry    = rect_read_addr[15:0];
    assign wr_ok = 32'(wx) < GRID_SIZE_X && 32'(wy) < GRID_SIZE_Y;
    assign rd_ok = 32'(rx) < GRID_SIZE_X && 32'(ry) < GRID_SIZE_Y;

    // Off-grid reads are walls so the controller sees the edge as ROCK
    assign rect_read_in = rd_ok ? mem_q[{ry[4:0], rx[4:0]}] : C_ROCK;
    assign vga_cell     = vga_cell_q;
    assign clear_busy   = state_q == SWEEP;
    assign oob_write    = oob_q;

`ifdef GRID_BORDER_ROCK_EN
    assign sweep_val = (cnt_q[4:0] == 5'd0 || cnt_q[4:0] == 5'(GRID_SIZE_X - 1) ||
                        cnt_q[9:5] == 5'd0 || cnt_q[9:5] == 5'(GRID_SIZE_Y - 1)) ? C_ROCK : C_NULL;
`else
    assign sweep_val = C_NULL;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear_req) begin
            state_d = SWEEP;
            cnt_d   = '0;
        end else if (state_q == SWEEP) begin
            state_d = cnt_q == 10'(NCELL - 1) ? IDLE : SWEEP;
            cnt_d   = cnt_q == 10'(NCELL - 1) ? '0 : cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SWEEP;
            cnt_q      <= '0;
            vga_cell_q <= '0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vga_cell_q <= 32'(vga_y) < GRID_SIZE_Y ? mem_q[{vga_y, vga_x}] : C_NULL;
            oob_q      <= state_q == IDLE && !wr_ok;
        end
    end

    // Sweep owns the write port; controller writes in that window are dropped
    always_ff @(posedge clk) begin
        if (state_q == SWEEP)
            mem_q[cnt_q] <= sweep_val;
        else if (wr_ok)
            mem_q[{wy[4:0], wx[4:0]}] <= rect_write[CELL_W-1:0];
    end
endmodule
